dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Shares the single-port data memory (sync write, async read) between the ARM core's data port and one auxiliary master (DMA / peripheral engine).
- The CPU has fixed priority. The aux master gets idle CPU cycles.
- When the aux master has waited too long, the CPU is stalled for a bounded burst.
- Sits between `arm`/`dmem` in the top level. The CPU keeps its single-cycle timing except during stall.

Parameters:
- ADDR_W, 32, address width of both masters and memory
- DATA_W, 32, data width
- STARVE_MAX, 8, consecutive blocked aux-request cycles before forced aux ownership (legal range 1..255)
- BURST_MAX, 4, maximum aux transfers per forced ownership period (legal range 1..255)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU data access this cycle (load or store)
- cpu_we  in  1  CPU store
- cpu_addr  in  ADDR_W  CPU address (ALUResult)
- cpu_wdata  in  DATA_W  CPU store data
- cpu_rdata  out  DATA_W  CPU load data
- cpu_stall  out  1  freeze CPU PC/regfile this cycle
- aux_req  in  1  aux access request, held until granted
- aux_we  in  1  aux write
- aux_addr  in  ADDR_W  aux address
- aux_wdata  in  DATA_W  aux write data
- aux_gnt  out  1  aux transfer performed this cycle
- aux_rvalid  out  1  aux read data valid (one cycle after a read grant)
- aux_rdata  out  DATA_W  registered aux read data
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory async read data

Behaviour:
- FSM has two states: CPU_OWN (reset state) and AUX_OWN.
- Reset (reset=0, async):
  - state=CPU_OWN, starve_cnt=0, burst_cnt=0.
  - aux_rvalid=0, aux_rdata=0.
  - cpu_stall=0, aux_gnt=0.
- CPU_OWN:
  - cpu_req=1: mem port = CPU (mem_we=cpu_we). aux_gnt=0. If aux_req=1, starve_cnt++.
  - cpu_req=0 and aux_req=1: mem port = aux (mem_we=aux_we). aux_gnt=1. starve_cnt←0.
  - Neither request: mem_we=0, mem_addr=cpu_addr, counters hold.
  - If aux_req=1, cpu_req=1 and starve_cnt==STARVE_MAX-1: next state=AUX_OWN, burst_cnt←0.
- AUX_OWN:
  - cpu_stall=1. mem port = aux.
  - aux_gnt=aux_req; each grant increments burst_cnt.
  - Return to CPU_OWN next cycle when aux_req=0, or when granting with burst_cnt==BURST_MAX-1. starve_cnt←0 on exit.
- cpu_stall, aux_gnt and the mem mux are combinational from state and requests. There is no added latency for the CPU.
- cpu_rdata=mem_rdata at all times. The CPU ignores it while stalled.
- Aux handshake:
  - aux_req/addr/we/wdata stay stable until the aux_gnt cycle.
  - Each aux_gnt cycle is exactly one transfer. The master may keep aux_req high for back-to-back transfers.
- Aux read: on an aux_gnt cycle with aux_we=0, aux_rdata←mem_rdata at the clock edge and aux_rvalid=1 for the following cycle only. Otherwise aux_rvalid=0 and aux_rdata holds.
- mem_we is never 1 for both masters. Only the owning master's we reaches memory.
- Widths: starve_cnt and burst_cnt are 8 bits and saturate. They never wrap.
- If aux_req drops without a grant (protocol violation), starve_cnt←0.
- Reset asserted mid-burst aborts immediately. Any pending aux_rvalid is lost.

Optional Feature:
- Macro: ARB_STATS_EN.
- Defined:
  - Adds outputs stat_stall_cycles [31:0] (cycles with cpu_stall=1) and stat_aux_xfers [31:0] (aux_gnt cycles).
  - Both are free-running, wrap at 2^32 and clear on reset.
- Undefined: ports and counters are absent, with no logic change otherwise.

Decomposition:
- Package dmem_arb_pkg contains:
  - typedef enum logic {CPU_OWN, AUX_OWN} arb_state_t
  - localparam CNT_W=8
  - a default-parameter constant set
- One sub-module, arb_sat_counter: saturating 8-bit counter with clear/inc/limit-hit. It is instantiated for starve_cnt and burst_cnt.
- The mux and FSM stay in dmem_arbiter.

Test Plan:
- Reset with reset=0 mid-burst → next cycle cpu_stall=0, aux_gnt=0, aux_rvalid=0, mem_we=0 (no requests).
- CPU store cpu_addr=0x40, cpu_wdata=0xDEADBEEF, aux idle → mem_we=1, mem_addr=0x40 same cycle, cpu_stall=0.
- Aux read aux_addr=0x80 with memory holding 0x12345678 while cpu_req=0 → aux_gnt=1 that cycle; aux_rvalid=1 and aux_rdata=0x12345678 next cycle.
- cpu_req=1 continuously, aux_req=1 (write) with STARVE_MAX=8, BURST_MAX=4 → aux_gnt=0 for 8 cycles, then cpu_stall=1 for exactly 4 cycles with 4 aux_gnt pulses, then CPU_OWN.
- Forced ownership with aux_req dropping after 2 grants → cpu_stall=1 for 3 cycles (2 grants + 1 exit cycle), stat_aux_xfers=2 when ARB_STATS_EN is defined.
- Simultaneous cpu_req=1, cpu_we=1 and aux_req=1, aux_we=1 to the same address → only the CPU write lands; aux write lands on the first later idle or forced cycle, never both.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and constants for the data-memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: ownership state enum, counter width, default parameter set.
package dmem_arb_pkg;

  localparam int CNT_W = 8;

  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_STARVE_MAX = 8;
  localparam int DEF_BURST_MAX  = 4;

  typedef enum logic {
    CPU_OWN = 1'b0,
    AUX_OWN = 1'b1
  } arb_state_t;

endpackage

// File: rtl/arb_sat_counter.sv
// arb_sat_counter: 8-bit saturating counter with synchronous clear and limit compare.
// Latency: count updates on the clock edge; hit is combinational from the count.
// Backpressure: none; inc at the all-ones value is ignored (saturates, never wraps).
// Ports: clk, reset (async active-low), clr (wins over inc), inc, limit, hit (cnt == limit).
module arb_sat_counter
  import dmem_arb_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  input  logic [CNT_W-1:0] limit,
  output logic             hit
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign hit = (cnt == limit);

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the CPU (fixed priority) and an aux master.
// Latency: CPU and aux grant paths are combinational; aux read data is registered, valid one cycle after grant.
// Backpressure: aux holds its request until aux_gnt; a starved aux forces a bounded CPU stall burst.
// Ports: clk, reset (async active-low); cpu_* data port with cpu_stall; aux_* request/grant/read-return;
// mem_* to the memory (sync write, async read). Optional macro ARB_STATS_EN adds
// stat_stall_cycles and stat_aux_xfers (free-running, wrapping, cleared on reset).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int STARVE_MAX = DEF_STARVE_MAX,
  parameter int BURST_MAX  = DEF_BURST_MAX
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              aux_req,
  input  logic              aux_we,
  input  logic [ADDR_W-1:0] aux_addr,
  input  logic [DATA_W-1:0] aux_wdata,
  output logic              aux_gnt,
  output logic              aux_rvalid,
  output logic [DATA_W-1:0] aux_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef ARB_STATS_EN
  ,
  output logic [31:0]       stat_stall_cycles,
  output logic [31:0]       stat_aux_xfers
`endif
);

  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX - 1);
  localparam logic [CNT_W-1:0] BURST_LIM  = CNT_W'(BURST_MAX - 1);

  arb_state_t state_q, state_d;
  logic       aux_sel;
  logic       starve_clr, starve_inc, starve_hit;
  logic       burst_clr, burst_inc, burst_hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= CPU_OWN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    cpu_stall  = 1'b0;
    aux_gnt    = 1'b0;
    aux_sel    = 1'b0;
    starve_clr = 1'b0;
    starve_inc = 1'b0;
    burst_clr  = 1'b0;
    burst_inc  = 1'b0;
    case (state_q)
      CPU_OWN: begin
        if (cpu_req) begin
          if (aux_req) begin
            starve_inc = 1'b1;
            if (starve_hit) begin
              state_d   = AUX_OWN;
              burst_clr = 1'b1;
            end
          end
        end else if (aux_req) begin
          aux_sel    = 1'b1;
          aux_gnt    = 1'b1;
          starve_clr = 1'b1;
        end
        // The starve count is only non-zero while aux has an ungranted request
        // outstanding, so aux_req low here means it was withdrawn: restart the count.
        if (!aux_req) starve_clr = 1'b1;
      end
      AUX_OWN: begin
        cpu_stall  = 1'b1;
        aux_sel    = 1'b1;
        aux_gnt    = aux_req;
        burst_inc  = aux_req;
        // Starve count is not consulted while aux owns the port; holding it
        // clear guarantees it is zero on the way out.
        starve_clr = 1'b1;
        if (!aux_req || burst_hit) state_d = CPU_OWN;
      end
    endcase
  end

  arb_sat_counter u_starve_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (starve_clr),
    .inc   (starve_inc),
    .limit (STARVE_LIM),
    .hit   (starve_hit)
  );

  arb_sat_counter u_burst_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (burst_clr),
    .inc   (burst_inc),
    .limit (BURST_LIM),
    .hit   (burst_hit)
  );

  // Only the selected master's write enable reaches memory, and aux only on a grant.
  assign mem_addr  = aux_sel ? aux_addr  : cpu_addr;
  assign mem_wdata = aux_sel ? aux_wdata : cpu_wdata;
  assign mem_we    = aux_sel ? (aux_we & aux_gnt) : (cpu_req & cpu_we);
  assign cpu_rdata = mem_rdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      aux_rvalid <= 1'b0;
      aux_rdata  <= '0;
    end else begin
      aux_rvalid <= aux_gnt & ~aux_we;
      if (aux_gnt && !aux_we) aux_rdata <= mem_rdata;
    end
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_stall_cycles <= '0;
      stat_aux_xfers    <= '0;
    end else begin
      if (cpu_stall) stat_stall_cycles <= stat_stall_cycles + 32'd1;
      if (aux_gnt)   stat_aux_xfers    <= stat_aux_xfers + 32'd1;
    end
  end
`endif

endmodule
